// File: rtl/regm_mp.sv
//------------------------------------------------------------------------------
// regm_mp
// Multi-port register file with same-cycle write bypass and a per-register
// busy scoreboard (set by issue, cleared by writeback).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module regm_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NREAD    = 2,
    parameter int NWRITE   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREAD*AW-1:0]     rd_addr,
    output logic [NREAD*WIDTH-1:0]  rd_data,
    output logic [NREAD-1:0]        rd_busy,
    input  logic [NWRITE-1:0]       wr_en,
    input  logic [NWRITE*AW-1:0]    wr_addr,
    input  logic [NWRITE*WIDTH-1:0] wr_data,
    input  logic                    issue_en,
    input  logic [AW-1:0]           issue_addr
);

    // Depth widened by one bit so the range check also works when DEPTH
    // is an exact power of two.
    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

    // An address is usable if it is in range and is not the hardwired zero
    // register.
    function automatic logic addr_valid(input logic [AW-1:0] a);
        logic ok;
        ok = ({1'b0, a} < C_DEPTH);
        if ((ZERO_REG == 1) && (a == '0)) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    // Architectural state.
    logic [WIDTH-1:0] regs     [DEPTH];
    logic [WIDTH-1:0] reg_nxt  [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;

    // Unpacked per-port views of the write bus.
    logic [AW-1:0]    wa [NWRITE];
    logic [WIDTH-1:0] wd [NWRITE];
    logic [NWRITE-1:0] wv;
    logic             iv;

    generate
        for (genvar j = 0; j < NWRITE; j++) begin : g_wp
            assign wa[j] = wr_addr[j*AW +: AW];
            assign wd[j] = wr_data[j*WIDTH +: WIDTH];
            assign wv[j] = wr_en[j] & addr_valid(wr_addr[j*AW +: AW]);
        end
    endgenerate

    assign iv = issue_en & addr_valid(issue_addr);

    // Next-state for data and busy: later write ports override earlier ones,
    // a write clears busy and a same-cycle issue sets it again.
    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            reg_nxt[r]  = regs[r];
            busy_nxt[r] = busy[r];
            for (int j = 0; j < NWRITE; j++) begin
                if (wv[j] && (wa[j] == AW'(r))) begin
                    reg_nxt[r]  = wd[j];
                    busy_nxt[r] = 1'b0;
                end
            end
            if (iv && (issue_addr == AW'(r))) begin
                busy_nxt[r] = 1'b1;
            end
        end
    end

    // State register; reset clears everything without waiting for an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
            end
            busy <= '0;
        end else begin
            regs <= reg_nxt;
            busy <= busy_nxt;
        end
    end

    generate
        for (genvar i = 0; i < NREAD; i++) begin : g_rp
            logic [AW-1:0]    ra;
            logic [WIDTH-1:0] dout;
            logic             bout;

            assign ra = rd_addr[i*AW +: AW];

            // Combinational read: invalid -> 0, else bypass from the highest
            // matching write port, else stored value. A matching write also
            // masks the busy flag since the producer completes this cycle.
            // While reset is held the outputs mirror the cleared state, so
            // in-flight writes are not bypassed.
            always_comb begin
                dout = '0;
                bout = 1'b0;
                if (!rst && addr_valid(ra)) begin
                    dout = regs[ra];
                    bout = busy[ra];
                    for (int j = 0; j < NWRITE; j++) begin
                        if (wv[j] && (wa[j] == ra)) begin
                            dout = wd[j];
                            bout = 1'b0;
                        end
                    end
                end
            end

            assign rd_data[i*WIDTH +: WIDTH] = dout;
            assign rd_busy[i]                = bout;
        end
    endgenerate

endmodule

`default_nettype wire

// File: doc/regm_mp.md
# regm_mp

Parametrised multi-port register file with write bypass and per-register busy scoreboard. It is the next-generation replacement for the single-write/dual-read register file in the pipelined core, and sits between decode (reads, issue marking) and writeback. It adds configurable width, depth and port counts, an asynchronous reset that clears all state, and busy tracking so decode can detect pending producers.

## Interface
- WIDTH, 32: data bits per register.
- DEPTH, 32: number of registers; AW = $clog2(DEPTH) address bits.
- NREAD, 2: read ports.
- NWRITE, 1: write ports.
- ZERO_REG, 1: 1 = register 0 reads 0, ignores writes, is never busy; 0 = register 0 behaves like any other register.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_addr  in  NREAD*AW  read addresses; port i at [i*AW +: AW].
- rd_data  out  NREAD*WIDTH  read data; port i at [i*WIDTH +: WIDTH].
- rd_busy  out  NREAD  per-port pending-producer flag.
- wr_en  in  NWRITE  write enables.
- wr_addr  in  NWRITE*AW  write addresses.
- wr_data  in  NWRITE*WIDTH  write data.
- issue_en  in  1  mark register issue_addr busy (a producer was issued).
- issue_addr  in  AW  register to mark busy.

## Operation
- Storage: DEPTH x WIDTH flops, plus a DEPTH-bit busy vector.
- Reset (rst=1, asynchronous): all registers go to 0 and all busy bits to 0 immediately. No writes or issues take effect while rst is high. Outputs follow combinationally from the cleared state.
- Write: on the rising edge, each port with wr_en=1 and a valid address stores wr_data.
  - A valid address is less than DEPTH and, when ZERO_REG=1, not 0. Writes to invalid addresses are dropped silently.
  - When several ports target the same address in one cycle, the highest-numbered port wins.
- Read is combinational. For each read port, in priority order:
  1. If the address is out of range (>= DEPTH), or it is 0 with ZERO_REG=1, return 0.
  2. If any enabled write port targets the same valid address this cycle, return the data of the highest-numbered such port (bypass).
  3. Otherwise return the stored value.
- Busy scoreboard, on the rising edge:
  - A valid write clears the busy bit for its address.
  - issue_en=1 with a valid issue_addr sets that address's bit.
  - If issue and write target the same address in one cycle, set wins: the new producer supersedes the completing one.
  - issue_addr that is invalid (out of range, or 0 with ZERO_REG=1) is ignored.
- rd_busy[i] is computed combinationally as busy[rd_addr_i] AND NOT (a valid write targets rd_addr_i this cycle).
  - It is 0 for invalid addresses.
  - An issue in the current cycle is not visible until the next cycle.

## Timing
- Read and bypass latency: 0 cycles (combinational from rd_addr, wr_*).
- A write becomes stored state 1 edge after wr_en; it is visible via bypass in the same cycle.
- A busy set becomes visible on rd_busy 1 cycle after issue_en. A busy clear is visible in the same cycle as the write (via bypass), and in stored state after the edge.
- Reset assertion takes effect without a clock edge. Deassertion is expected synchronous to clk (the synchroniser is external). The first write or issue is accepted on the first rising edge with rst=0.
- Reset mid-operation: in-flight writes and issues from that cycle are discarded. All rd_data become 0 and all rd_busy become 0.
- No handshake. Every port is accepted every cycle, with no back-pressure.

## Test plan
- Reset: preload r5=0xDEADBEEF, assert rst between clock edges. Required: rd_data for r5 reads 0 before the next edge, and every rd_busy is 0.
- Zero register (ZERO_REG=1): write 0x1234 to r0 and issue r0. Required: r0 reads 0 and rd_busy=0. With ZERO_REG=0 the same stimulus returns 0x1234 on the next cycle and busy=1.
- Bypass and write conflict (NWRITE=2): in one cycle, port0 writes r7=0xAAAA0000 and port1 writes r7=0x5555FFFF while read port 0 reads r7. Required: the same-cycle read returns 0x5555FFFF, and the stored value is still 0x5555FFFF the next cycle.
- Scoreboard: issue r3 at cycle N. Required: rd_busy=1 from N+1. Then write r3=0x42 at cycle M. Required: rd_busy=0 and rd_data=0x42 in cycle M, with the busy bit clear in stored state afterwards.
- Issue and write collide on r9 in the same cycle. Required: rd_busy for r9 is 1 the next cycle, and the stored data equals the written value.
- Range (DEPTH=20): write 0x77 to address 25 and read address 25. Required: the read returns 0, rd_busy is 0, and no stored register changes (readback of all 20 registers matches the pre-write values).
